// File: rtl/haz_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// scoreboard entry layout and the zero-register index.
package haz_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       use_rn;
    logic       use_rm;
    logic       reg_write;
    logic       mem_read;
    logic       flag_set;
  } sb_entry_t;

endpackage

// File: rtl/haz_src_check.sv
// Compares one source register against one in-flight writer; writes to XZR
// never match, since X31 reads as zero regardless of any writer.
module haz_src_check
  import haz_pkg::*;
(
  input  logic [4:0] src,
  input  logic       src_used,
  input  sb_entry_t  entry,
  output logic       match,
  output logic       is_load
);

  assign match   = src_used & entry.valid & entry.reg_write &
                   (entry.rd == src) & (src != XZR);
  assign is_load = match & entry.mem_read;

  logic unused_fields;
  assign unused_fields = ^{entry.rn, entry.rm, entry.use_rn, entry.use_rm, entry.flag_set};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding/stall controller for the 5-stage pipeline.
// Define HAZ_FORWARD_EN to enable forwarding; otherwise every RAW hazard stalls.
module pipeline_hazard_ctrl
  import haz_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic        id_use_rn,
  input  logic        id_use_rm,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_flag_set,
  input  logic        id_cbz,
  input  logic        id_bcond,
  input  logic        id_br_taken,
  output logic        stall,
  output logic        flush_if,
  output logic        id_kill,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  fwd_cbz,
  output logic        fwd_flags,
  output logic [15:0] stall_cnt
);

  sb_entry_t   ex_q, mem_q, wb_q, id_entry;
  sb_entry_t   stage [3];
  logic        squash_q, boot_q;
  logic [15:0] cnt_q;
  logic        id_live;
  logic [4:0]  id_src [2];
  logic        id_use [2];
  logic [4:0]  ex_src [2];
  logic        ex_use [2];
  logic        id_hit [2][3];
  logic        id_ld  [2][3];
  logic        ex_hit [2][2];
  logic        ex_ld  [2][2];
  logic        stall_raw, flags_raw;
  fwd_sel_t    fwd_a_raw, fwd_b_raw, fwd_cbz_raw;

  assign id_live   = id_valid & ~squash_q;
  assign id_src[0] = id_rn;
  assign id_src[1] = id_rm;
  assign id_use[0] = id_live & id_use_rn;
  assign id_use[1] = id_live & id_use_rm;
  assign ex_src[0] = ex_q.rn;
  assign ex_src[1] = ex_q.rm;
  assign ex_use[0] = ex_q.valid & ex_q.use_rn;
  assign ex_use[1] = ex_q.valid & ex_q.use_rm;
  assign stage[0]  = ex_q;
  assign stage[1]  = mem_q;
  assign stage[2]  = wb_q;

  assign id_entry = '{valid: 1'b1, rd: id_rd, rn: id_rn, rm: id_rm,
                      use_rn: id_use_rn, use_rm: id_use_rm, reg_write: id_reg_write,
                      mem_read: id_mem_read, flag_set: id_flag_set};

  // ID sources against EX/MEM/WB writers; EX operands against MEM/WB writers.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    for (genvar gj = 0; gj < 3; gj++) begin : g_id
      haz_src_check u_id (
        .src(id_src[gi]), .src_used(id_use[gi]), .entry(stage[gj]),
        .match(id_hit[gi][gj]), .is_load(id_ld[gi][gj])
      );
    end
    for (genvar gj = 0; gj < 2; gj++) begin : g_ex
      haz_src_check u_ex (
        .src(ex_src[gi]), .src_used(ex_use[gi]), .entry(stage[gj+1]),
        .match(ex_hit[gi][gj]), .is_load(ex_ld[gi][gj])
      );
    end
  end

  always_comb begin
    stall_raw   = 1'b0;
    flags_raw   = 1'b0;
    fwd_a_raw   = FWD_REG;
    fwd_b_raw   = FWD_REG;
    fwd_cbz_raw = FWD_REG;
`ifdef HAZ_FORWARD_EN
    // CBZ compares in ID, so an EX-stage result or a MEM-stage load is too late.
    stall_raw = id_ld[0][0] | id_ld[1][0] |
                (id_cbz & (id_hit[1][0] | id_ld[1][1]));
    if (id_cbz) begin
      if (id_hit[1][1] & ~id_ld[1][1]) fwd_cbz_raw = FWD_EXMEM;
      else if (id_hit[1][2])           fwd_cbz_raw = FWD_MEMWB;
    end
    if (ex_hit[0][0] & ~ex_ld[0][0]) fwd_a_raw = FWD_EXMEM;
    else if (ex_hit[0][1])           fwd_a_raw = FWD_MEMWB;
    if (ex_hit[1][0] & ~ex_ld[1][0]) fwd_b_raw = FWD_EXMEM;
    else if (ex_hit[1][1])           fwd_b_raw = FWD_MEMWB;
    flags_raw = id_live & id_bcond & ex_q.valid & ex_q.flag_set;
`else
    stall_raw = id_hit[0][0] | id_hit[0][1] | id_hit[0][2] |
                id_hit[1][0] | id_hit[1][1] | id_hit[1][2] |
                (id_live & id_bcond & ((ex_q.valid & ex_q.flag_set) |
                                       (mem_q.valid & mem_q.flag_set)));
`endif
  end

  // boot_q masks all control outputs during reset and the first cycle after it.
  assign stall     = ~boot_q & stall_raw;
  assign flush_if  = ~boot_q & id_live & id_br_taken & ~stall_raw;
  assign id_kill   = squash_q;
  assign fwd_a     = boot_q ? FWD_REG : fwd_a_raw;
  assign fwd_b     = boot_q ? FWD_REG : fwd_b_raw;
  assign fwd_cbz   = boot_q ? FWD_REG : fwd_cbz_raw;
  assign fwd_flags = ~boot_q & flags_raw;
  assign stall_cnt = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      squash_q <= 1'b0;
      boot_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      boot_q   <= 1'b0;
      wb_q     <= mem_q;
      mem_q    <= ex_q;
      ex_q     <= (id_live & ~stall) ? id_entry : '0;
      squash_q <= flush_if;
      if (stall && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  logic unused_sinks;
`ifdef HAZ_FORWARD_EN
  assign unused_sinks = ^{id_ld[0][1], id_ld[0][2], id_ld[1][2], ex_ld[0][1], ex_ld[1][1]};
`else
  assign unused_sinks = ^{id_cbz, id_ld[0][0], id_ld[0][1], id_ld[0][2], id_ld[1][0],
                          id_ld[1][1], id_ld[1][2], ex_hit[0][0], ex_hit[0][1],
                          ex_hit[1][0], ex_hit[1][1], ex_ld[0][0], ex_ld[0][1],
                          ex_ld[1][0], ex_ld[1][1]};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expectations follow HAZ_FORWARD_EN.
module tb_pipeline_hazard_ctrl;

`ifdef HAZ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, reset, id_valid;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        id_use_rn, id_use_rm, id_reg_write, id_mem_read, id_flag_set;
  logic        id_cbz, id_bcond, id_br_taken;
  logic        stall, flush_if, id_kill, fwd_flags;
  logic [1:0]  fwd_a, fwd_b, fwd_cbz;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_flag_set(id_flag_set),
    .id_cbz(id_cbz), .id_bcond(id_bcond), .id_br_taken(id_br_taken),
    .stall(stall), .flush_if(flush_if), .id_kill(id_kill), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .fwd_cbz(fwd_cbz), .fwd_flags(fwd_flags), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
    $display("[TB] check %-16s observed %0h expected %0h", tag, obs, want);
  endtask

  task automatic set_id(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm, input logic rw, input logic mr,
                        input logic fs, input logic cbz, input logic bc, input logic br);
    id_valid = 1'b1; id_rd = rd; id_rn = rn; id_rm = rm;
    id_use_rn = urn; id_use_rm = urm; id_reg_write = rw; id_mem_read = mr;
    id_flag_set = fs; id_cbz = cbz; id_bcond = bc; id_br_taken = br;
    #1;
  endtask

  task automatic nop();
    id_valid = 1'b0; id_rd = '0; id_rn = '0; id_rm = '0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_flag_set = 1'b0; id_cbz = 1'b0; id_bcond = 1'b0; id_br_taken = 1'b0;
    #1;
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) step();
  endtask

  // Holds the current ID instruction, expecting exactly n stall cycles.
  task automatic hold_stall(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, {15'd0, stall}, 16'd1);
      exp_cnt++;
      step();
    end
    chk(tag, {15'd0, stall}, 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    // Taken branch in ID during reset must not flush.
    set_id(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(); step();
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_flush", {15'd0, flush_if}, 16'd0);
    chk("rst_kill", {15'd0, id_kill}, 16'd0);
    chk("rst_fwd", {10'd0, fwd_a, fwd_b, fwd_cbz}, 16'd0);
    chk("rst_cnt", stall_cnt, 16'd0);
    reset = 1'b0;
    #1;
    chk("boot_flush", {15'd0, flush_if}, 16'd0);
    step();
    chk("br_flush", {15'd0, flush_if}, 16'd1);
    step();
    nop();
    chk("br_kill", {15'd0, id_kill}, 16'd1);
    step();
    chk("br_kill_clr", {15'd0, id_kill}, 16'd0);

    // ADD X1 ; SUB X4,X1,X5 back to back
    drain();
    set_id(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("add_nostall", {15'd0, stall}, 16'd0);
    step();
    set_id(5'd4, 5'd1, 5'd5, 1, 1, 1, 0, 0, 0, 0, 0);
    hold_stall("exmem_stall", FWD ? 0 : 3);
    step();
    nop();
    chk("fwd_a_exmem", {14'd0, fwd_a}, FWD ? 16'd1 : 16'd0);
    chk("fwd_b_exmem", {14'd0, fwd_b}, 16'd0);
    chk("cnt_a", stall_cnt, exp_cnt[15:0]);

    // ADD X6 ; nop ; SUB X7,X6,X8
    drain();
    set_id(5'd6, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0, 0, 0);
    step();
    nop();
    step();
    set_id(5'd7, 5'd6, 5'd8, 1, 1, 1, 0, 0, 0, 0, 0);
    hold_stall("memwb_stall", FWD ? 0 : 2);
    step();
    nop();
    chk("fwd_a_memwb", {14'd0, fwd_a}, FWD ? 16'd2 : 16'd0);
    chk("cnt_b", stall_cnt, exp_cnt[15:0]);

    // LDUR X2 ; ADD X3,X4,X2 (load-use)
    drain();
    set_id(5'd2, 5'd9, 5'd0, 1, 0, 1, 1, 0, 0, 0, 0);
    step();
    set_id(5'd3, 5'd4, 5'd2, 1, 1, 1, 0, 0, 0, 0, 0);
    hold_stall("ld_use_stall", FWD ? 1 : 3);
    step();
    nop();
    chk("ld_fwd_b", {14'd0, fwd_b}, FWD ? 16'd2 : 16'd0);
    chk("ld_fwd_a", {14'd0, fwd_a}, 16'd0);
    chk("cnt_ld", stall_cnt, exp_cnt[15:0]);

    // LDUR X5 ; CBZ X5 taken, then the squashed slot
    drain();
    set_id(5'd5, 5'd9, 5'd0, 1, 0, 1, 1, 0, 0, 0, 0);
    step();
    set_id(5'd0, 5'd0, 5'd5, 0, 1, 0, 0, 0, 1, 0, 1);
    chk("cbz_flush_hold", {15'd0, flush_if}, 16'd0);
    hold_stall("cbz_ld_stall", FWD ? 2 : 3);
    chk("fwd_cbz_memwb", {14'd0, fwd_cbz}, FWD ? 16'd2 : 16'd0);
    chk("cbz_flush", {15'd0, flush_if}, 16'd1);
    step();
    set_id(5'd12, 5'd13, 5'd14, 1, 1, 1, 0, 0, 0, 0, 1);
    chk("kill_set", {15'd0, id_kill}, 16'd1);
    chk("kill_noflush", {15'd0, flush_if}, 16'd0);
    step();
    set_id(5'd15, 5'd12, 5'd0, 1, 0, 1, 0, 0, 0, 0, 0);
    chk("kill_clr", {15'd0, id_kill}, 16'd0);
    chk("kill_bubble", {15'd0, stall}, 16'd0);
    step();
    nop();
    chk("kill_nofwd", {14'd0, fwd_a}, 16'd0);
    chk("cnt_cbz", stall_cnt, exp_cnt[15:0]);

    // ADD X10 ; CBZ X10 not taken
    drain();
    set_id(5'd10, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0, 0, 0);
    step();
    set_id(5'd0, 5'd0, 5'd10, 0, 1, 0, 0, 0, 1, 0, 0);
    hold_stall("cbz_alu_stall", FWD ? 1 : 3);
    chk("fwd_cbz_exmem", {14'd0, fwd_cbz}, FWD ? 16'd1 : 16'd0);
    chk("cbz_nt_flush", {15'd0, flush_if}, 16'd0);

    // ADD X31 ; SUB reading X31
    drain();
    set_id(5'd31, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0, 0, 0);
    step();
    set_id(5'd16, 5'd31, 5'd31, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("xzr_stall", {15'd0, stall}, 16'd0);
    step();
    nop();
    chk("xzr_fwd", {12'd0, fwd_a, fwd_b}, 16'd0);

    // SUBS ; B.LT
    drain();
    set_id(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 1, 0, 0, 0);
    step();
    set_id(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("fwd_flags", {15'd0, fwd_flags}, FWD ? 16'd1 : 16'd0);
    hold_stall("bcond_stall", FWD ? 0 : 2);
    chk("cnt_bcond", stall_cnt, exp_cnt[15:0]);

    // Reset in the middle of a load-use stall
    drain();
    set_id(5'd2, 5'd9, 5'd0, 1, 0, 1, 1, 0, 0, 0, 0);
    step();
    set_id(5'd3, 5'd4, 5'd2, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_stall", {15'd0, stall}, 16'd1);
    reset = 1'b1;
    #1;
    exp_cnt = 0;
    chk("mid_rst_stall", {15'd0, stall}, 16'd0);
    chk("mid_rst_cnt", stall_cnt, 16'd0);
    chk("mid_rst_fwd", {10'd0, fwd_a, fwd_b, fwd_cbz}, 16'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_boot", {15'd0, stall}, 16'd0);
    step();
    chk("post_rst_empty", {15'd0, stall}, 16'd0);
    chk("post_rst_cnt", stall_cnt, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
